// File: rtl/ray_dispatch_engine.sv
// ray_dispatch_engine
//   Pixel scheduler and result collector for a bank of ray-marching cores.
//   A frame request latches the scene and screen geometry, then the screen is
//   walked in raster order in steps of 2^decim, one job per cycle, each job
//   going to the lowest-indexed idle core. Finished results are gathered by a
//   round-robin arbiter into a single valid/ready output register. A done
//   pulse follows the last result of the frame being taken downstream.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-low reset
//   display_width_in/height   active screen size, sampled at frame start
//   decim_in                  decimation exponent, clamped to MAX_DECIM
//   scene_in / scene_out      scene state in, latched copy broadcast to cores
//   frame_req_in              start a frame (only honoured while idle)
//   job_h/v_out, job_valid    job coordinate and one-hot per-core strobe
//   core_idle_in              per-core "can take a job"
//   core_res_*_in             per-core held result, valid until acked
//   core_res_ack_out          one-hot result acknowledge
//   pix_*                     output pixel stream, valid/ready
//   busy_out, new_frame_out, frame_done_out   frame status
//
// state  | meaning
// IDLE   | waiting for frame_req_in
// ISSUE  | walking the screen, handing out one job per cycle
// DRAIN  | all jobs issued, waiting for results to leave the output register
module ray_dispatch_engine #(
  parameter int NUM_CORES  = 8,
  parameter int H_BITS     = 11,
  parameter int V_BITS     = 10,
  parameter int COLOR_BITS = 4,
  parameter int SCENE_BITS = 196,
  parameter int MAX_DECIM  = 3
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [H_BITS-1:0]              display_width_in,
  input  logic [V_BITS-1:0]              display_height_in,
  input  logic [1:0]                     decim_in,
  input  logic [SCENE_BITS-1:0]          scene_in,
  input  logic                           frame_req_in,
  output logic [SCENE_BITS-1:0]          scene_out,
  output logic [H_BITS-1:0]              job_h_out,
  output logic [V_BITS-1:0]              job_v_out,
  output logic [NUM_CORES-1:0]           job_valid_out,
  input  logic [NUM_CORES-1:0]           core_idle_in,
  input  logic [NUM_CORES-1:0]           core_res_valid_in,
  input  logic [NUM_CORES*H_BITS-1:0]    core_res_h_in,
  input  logic [NUM_CORES*V_BITS-1:0]    core_res_v_in,
  input  logic [NUM_CORES*COLOR_BITS-1:0] core_res_color_in,
  output logic [NUM_CORES-1:0]           core_res_ack_out,
  output logic [H_BITS-1:0]              pix_h_out,
  output logic [V_BITS-1:0]              pix_v_out,
  output logic [1:0]                     pix_size_out,
  output logic [COLOR_BITS-1:0]          pix_color_out,
  output logic                           pix_valid_out,
  input  logic                           pix_ready_in,
  output logic                           busy_out,
  output logic                           new_frame_out,
  output logic                           frame_done_out
);

  localparam int OBITS = $clog2(NUM_CORES + 1);
  localparam int IBITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0] DECIM_MAX = 2'(MAX_DECIM);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t state_q, state_d;

  logic [H_BITS-1:0]    width_q, h_q, step_h;
  logic [V_BITS-1:0]    height_q, v_q, step_v;
  logic [H_BITS:0]      h_sum;
  logic [V_BITS:0]      v_sum;
  logic [1:0]           decim_q, decim_clamped;
  logic [OBITS-1:0]     outstanding_q;
  logic [IBITS-1:0]     last_grant_q, res_idx, cand_idx;
  logic [NUM_CORES-1:0] idle_avail, issue_oh, res_cand, ack_oh;
  logic                 issue_fire, row_wrap, last_row, out_free;
  logic                 res_found, grant, start_frame, done_d;

  assign decim_clamped = (decim_in > DECIM_MAX) ? DECIM_MAX : decim_in;
  assign start_frame   = (state_q == S_IDLE) && frame_req_in;

  assign step_h   = H_BITS'(1) << decim_q;
  assign step_v   = V_BITS'(1) << decim_q;
  assign h_sum    = {1'b0, h_q} + {1'b0, step_h};
  assign v_sum    = {1'b0, v_q} + {1'b0, step_v};
  assign row_wrap = h_sum >= {1'b0, width_q};
  assign last_row = v_sum >= {1'b0, height_q};

  // The core strobed last cycle may still show idle; never hand it a second job.
  assign idle_avail = core_idle_in & ~job_valid_out;
  assign issue_oh   = idle_avail & (~idle_avail + NUM_CORES'(1));
  assign issue_fire = (state_q == S_ISSUE) && (|idle_avail);

  // A core being acked this cycle still shows valid until it sees the ack.
  assign res_cand = core_res_valid_in & ~core_res_ack_out;
  assign out_free = !pix_valid_out || pix_ready_in;

  always_comb begin
    res_found = 1'b0;
    res_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand_idx = IBITS'((int'(last_grant_q) + k) % NUM_CORES);
      if (!res_found && res_cand[cand_idx]) begin
        res_found = 1'b1;
        res_idx   = cand_idx;
      end
    end
  end

  assign grant    = out_free && res_found;
  assign ack_oh   = NUM_CORES'(1) << res_idx;
  assign busy_out = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_req_in) begin
          if (display_width_in == '0 || display_height_in == '0) state_d = S_DRAIN;
          else                                                    state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_fire && row_wrap && last_row) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outstanding_q == '0 && out_free) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      scene_out        <= '0;
      width_q          <= '0;
      height_q         <= '0;
      decim_q          <= '0;
      h_q              <= '0;
      v_q              <= '0;
      outstanding_q    <= '0;
      job_h_out        <= '0;
      job_v_out        <= '0;
      job_valid_out    <= '0;
      core_res_ack_out <= '0;
      last_grant_q     <= IBITS'(NUM_CORES - 1);
      pix_h_out        <= '0;
      pix_v_out        <= '0;
      pix_size_out     <= '0;
      pix_color_out    <= '0;
      pix_valid_out    <= 1'b0;
      new_frame_out    <= 1'b0;
      frame_done_out   <= 1'b0;
    end else begin
      new_frame_out    <= 1'b0;
      frame_done_out   <= done_d;
      job_valid_out    <= '0;
      core_res_ack_out <= '0;

      if (start_frame) begin
        scene_out     <= scene_in;
        width_q       <= display_width_in;
        height_q      <= display_height_in;
        decim_q       <= decim_clamped;
        h_q           <= '0;
        v_q           <= '0;
        new_frame_out <= 1'b1;
      end

      if (issue_fire) begin
        job_valid_out <= issue_oh;
        job_h_out     <= h_q;
        job_v_out     <= v_q;
        if (row_wrap) begin
          h_q <= '0;
          v_q <= v_sum[V_BITS-1:0];
        end else begin
          h_q <= h_sum[H_BITS-1:0];
        end
      end

      if (start_frame)              outstanding_q <= '0;
      else if (issue_fire && !grant) outstanding_q <= outstanding_q + OBITS'(1);
      else if (!issue_fire && grant) outstanding_q <= outstanding_q - OBITS'(1);

      if (out_free) begin
        if (res_found) begin
          pix_valid_out    <= 1'b1;
          pix_h_out        <= core_res_h_in[int'(res_idx)*H_BITS +: H_BITS];
          pix_v_out        <= core_res_v_in[int'(res_idx)*V_BITS +: V_BITS];
          pix_color_out    <= core_res_color_in[int'(res_idx)*COLOR_BITS +: COLOR_BITS];
          pix_size_out     <= decim_q;
          core_res_ack_out <= ack_oh;
          last_grant_q     <= res_idx;
        end else begin
          pix_valid_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ray_dispatch_engine.sv
module tb_ray_dispatch_engine;

  localparam int NC = 4;
  localparam int HB = 11;
  localparam int VB = 10;
  localparam int CB = 4;
  localparam int SB = 196;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic [HB-1:0]     display_width_in = '0;
  logic [VB-1:0]     display_height_in = '0;
  logic [1:0]        decim_in = '0;
  logic [SB-1:0]     scene_in = '0;
  logic              frame_req_in = 1'b0;
  logic [SB-1:0]     scene_out;
  logic [HB-1:0]     job_h_out;
  logic [VB-1:0]     job_v_out;
  logic [NC-1:0]     job_valid_out;
  logic [NC-1:0]     core_idle_in = '1;
  logic [NC-1:0]     core_res_valid_in = '0;
  logic [NC*HB-1:0]  core_res_h_in = '0;
  logic [NC*VB-1:0]  core_res_v_in = '0;
  logic [NC*CB-1:0]  core_res_color_in = '0;
  logic [NC-1:0]     core_res_ack_out;
  logic [HB-1:0]     pix_h_out;
  logic [VB-1:0]     pix_v_out;
  logic [1:0]        pix_size_out;
  logic [CB-1:0]     pix_color_out;
  logic              pix_valid_out;
  logic              pix_ready_in = 1'b1;
  logic              busy_out, new_frame_out, frame_done_out;

  ray_dispatch_engine #(.NUM_CORES(NC), .H_BITS(HB), .V_BITS(VB), .COLOR_BITS(CB),
                        .SCENE_BITS(SB), .MAX_DECIM(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .display_width_in(display_width_in), .display_height_in(display_height_in),
    .decim_in(decim_in), .scene_in(scene_in), .frame_req_in(frame_req_in),
    .scene_out(scene_out), .job_h_out(job_h_out), .job_v_out(job_v_out),
    .job_valid_out(job_valid_out), .core_idle_in(core_idle_in),
    .core_res_valid_in(core_res_valid_in), .core_res_h_in(core_res_h_in),
    .core_res_v_in(core_res_v_in), .core_res_color_in(core_res_color_in),
    .core_res_ack_out(core_res_ack_out), .pix_h_out(pix_h_out), .pix_v_out(pix_v_out),
    .pix_size_out(pix_size_out), .pix_color_out(pix_color_out),
    .pix_valid_out(pix_valid_out), .pix_ready_in(pix_ready_in),
    .busy_out(busy_out), .new_frame_out(new_frame_out), .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {int h; int v; int c; int s;} pix_t;

  int n_checks = 0;
  int n_fail   = 0;

  // core model state
  bit busy_c[NC];
  bit holding[NC];
  int cnt[NC];
  int res_h[NC];
  int res_v[NC];
  int lat_min = 3, lat_max = 3, ready_pct = 100;
  bit ready_rand = 1'b0;

  // observation
  pix_t out_q[$];
  int   ack_log[$];
  bit   exp_set[int];
  bit   seen_job[int];
  int   job_cnt, done_cnt, newf_cnt, done_at, first_key;

  logic [NC-1:0] snap_idle;
  logic          snap_valid, snap_ready;
  logic [HB-1:0] snap_h;
  logic [VB-1:0] snap_v;
  logic [CB-1:0] snap_c;
  logic [1:0]    snap_s;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int col_of(input int h, input int v);
    return (h * 3 + v * 5 + 1) & 15;
  endfunction

  function automatic int key_of(input int h, input int v);
    return v * 4096 + h;
  endfunction

  task automatic drive_cores();
    for (int i = 0; i < NC; i++) begin
      core_idle_in[i]      = !busy_c[i] && !holding[i];
      core_res_valid_in[i] = holding[i];
      core_res_h_in[i*HB +: HB]     = HB'(res_h[i]);
      core_res_v_in[i*VB +: VB]     = VB'(res_v[i]);
      core_res_color_in[i*CB +: CB] = CB'(col_of(res_h[i], res_v[i]));
    end
    snap_idle  = core_idle_in;
    snap_valid = pix_valid_out;
    snap_ready = pix_ready_in;
    snap_h = pix_h_out;
    snap_v = pix_v_out;
    snap_c = pix_color_out;
    snap_s = pix_size_out;
  endtask

  task automatic clear_cores();
    for (int i = 0; i < NC; i++) begin
      busy_c[i] = 1'b0; holding[i] = 1'b0; cnt[i] = 0; res_h[i] = 0; res_v[i] = 0;
    end
  endtask

  task automatic tick();
    logic [NC-1:0] exp_job;
    int k;
    @(posedge clk_in);
    #1;
    if (snap_valid && snap_ready)
      out_q.push_back('{int'(snap_h), int'(snap_v), int'(snap_c), int'(snap_s)});
    if (snap_valid && !snap_ready) begin
      check_val("pix_hold_valid", pix_valid_out, 1);
      check_val("pix_hold_data", {pix_h_out, pix_v_out, pix_color_out, pix_size_out},
                {snap_h, snap_v, snap_c, snap_s});
    end
    if (new_frame_out) newf_cnt++;
    if (frame_done_out) begin
      done_cnt++;
      done_at = out_q.size();
    end
    if (core_res_ack_out != '0) begin
      check_val("ack_onehot", $onehot(core_res_ack_out), 1);
      for (int i = 0; i < NC; i++)
        if (core_res_ack_out[i]) begin
          ack_log.push_back(i);
          check_val("ack_held", holding[i], 1);
          holding[i] = 1'b0;
        end
    end
    for (int i = 0; i < NC; i++)
      if (busy_c[i]) begin
        cnt[i]--;
        if (cnt[i] <= 0) begin busy_c[i] = 1'b0; holding[i] = 1'b1; end
      end
    if (job_valid_out != '0) begin
      exp_job = snap_idle & (~snap_idle + NC'(1));
      check_val("job_lowest_idle", job_valid_out, exp_job);
      job_cnt++;
      k = key_of(int'(job_h_out), int'(job_v_out));
      check_val("job_in_frame", exp_set.exists(k), 1);
      check_val("job_unique", seen_job.exists(k), 0);
      seen_job[k] = 1'b1;
      if (job_cnt == 1) first_key = k;
      for (int i = 0; i < NC; i++)
        if (job_valid_out[i]) begin
          busy_c[i] = 1'b1;
          cnt[i]    = $urandom_range(lat_max, lat_min);
          res_h[i]  = int'(job_h_out);
          res_v[i]  = int'(job_v_out);
        end
    end
    if (ready_rand) pix_ready_in = ($urandom_range(99, 0) < ready_pct);
    drive_cores();
  endtask

  task automatic hold_mask(input logic [NC-1:0] m);
    for (int i = 0; i < NC; i++)
      if (m[i]) begin
        holding[i] = 1'b1; busy_c[i] = 1'b0; res_h[i] = i * 5 + 2; res_v[i] = i + 1;
      end
    drive_cores();
  endtask

  task automatic rr_round(input string tag, input logic [NC-1:0] m, input int e0, input int e1,
                          input int e2, input int e3);
    int exp_ord[4];
    int n;
    exp_ord = '{e0, e1, e2, e3};
    n = $countones(m);
    ack_log.delete();
    out_q.delete();
    hold_mask(m);
    repeat (8) tick();
    check_val({tag, "_acks"}, ack_log.size(), n);
    check_val({tag, "_outs"}, out_q.size(), n);
    for (int j = 0; j < n && j < ack_log.size() && j < out_q.size(); j++) begin
      check_val({tag, "_order"}, ack_log[j], exp_ord[j]);
      check_val({tag, "_data"}, {out_q[j].h, out_q[j].v, out_q[j].c},
                {exp_ord[j] * 5 + 2, exp_ord[j] + 1, col_of(exp_ord[j] * 5 + 2, exp_ord[j] + 1)});
    end
  endtask

  task automatic start_frame(input int w, input int ht, input int d, output logic [SB-1:0] sc);
    logic [223:0] r;
    int step;
    step = 1 << ((d > 3) ? 3 : d);
    exp_set.delete(); seen_job.delete(); out_q.delete(); ack_log.delete();
    job_cnt = 0; done_cnt = 0; newf_cnt = 0; done_at = -1; first_key = -1;
    for (int vv = 0; vv < ht; vv += step)
      for (int hh = 0; hh < w; hh += step) exp_set[key_of(hh, vv)] = 1'b1;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    sc = r[SB-1:0];
    display_width_in = HB'(w); display_height_in = VB'(ht); decim_in = 2'(d);
    scene_in = sc; frame_req_in = 1'b1;
    tick();
    frame_req_in = 1'b0;
    scene_in = ~sc;
    display_width_in = HB'($urandom_range(2047, 0));
    display_height_in = VB'($urandom_range(1023, 0));
    decim_in = 2'($urandom_range(3, 0));
  endtask

  task automatic run_frame(input int w, input int ht, input int d, input int lmin, input int lmax,
                           input int rpct, input bit inject);
    logic [SB-1:0] sc;
    int n_exp, cyc, dd, k;
    bit seen_out[int];
    lat_min = lmin; lat_max = lmax; ready_pct = rpct; ready_rand = 1'b1;
    dd = (d > 3) ? 3 : d;
    start_frame(w, ht, d, sc);
    n_exp = exp_set.num();
    check_val("new_frame_pulse", newf_cnt, 1);
    check_val("busy_start", busy_out, 1);
    check_val("scene_latch", scene_out, sc);
    if (n_exp == 0) begin
      tick();
      check_val("degen_done_timing", done_cnt, 1);
    end else begin
      cyc = 0;
      while (done_cnt == 0 && cyc < 4000) begin
        if (inject && cyc == 4) begin
          scene_in = ~sc;
          frame_req_in = 1'b1;
        end
        tick();
        frame_req_in = 1'b0;
        cyc++;
      end
    end
    repeat (4) tick();
    check_val("done_count", done_cnt, 1);
    check_val("busy_end", busy_out, 0);
    check_val("new_frame_count", newf_cnt, 1);
    check_val("scene_held", scene_out, sc);
    check_val("job_count", job_cnt, n_exp);
    check_val("out_count", out_q.size(), n_exp);
    check_val("done_after_last", done_at, n_exp);
    if (n_exp > 0) check_val("first_job_origin", first_key, key_of(0, 0));
    foreach (out_q[j]) begin
      k = key_of(out_q[j].h, out_q[j].v);
      check_val("out_in_frame", exp_set.exists(k), 1);
      check_val("out_unique", seen_out.exists(k), 0);
      seen_out[k] = 1'b1;
      check_val("out_color", out_q[j].c, col_of(out_q[j].h, out_q[j].v));
      check_val("out_size", out_q[j].s, dd);
    end
  endtask

  task automatic reset_mid_frame();
    logic [SB-1:0] sc;
    int cyc;
    lat_min = 3; lat_max = 3; ready_rand = 1'b1; ready_pct = 100;
    start_frame(8, 2, 0, sc);
    cyc = 0;
    while (job_cnt < 5 && cyc < 100) begin tick(); cyc++; end
    check_val("rst_reached_job5", job_cnt, 5);
    rst_in = 1'b0;
    tick();
    check_val("rst_job_valid", job_valid_out, 0);
    check_val("rst_ack", core_res_ack_out, 0);
    check_val("rst_pix_valid", pix_valid_out, 0);
    check_val("rst_busy", busy_out, 0);
    check_val("rst_new_frame", new_frame_out, 0);
    check_val("rst_done", frame_done_out, 0);
    check_val("rst_scene", scene_out, 0);
    check_val("rst_job_hv", {job_h_out, job_v_out}, 0);
    check_val("rst_pix_data", {pix_h_out, pix_v_out, pix_color_out, pix_size_out}, 0);
    rst_in = 1'b1;
    clear_cores();
    drive_cores();
    done_cnt = 0;
    repeat (6) tick();
    check_val("rst_no_done", done_cnt, 0);
    check_val("rst_stays_idle", busy_out, 0);
  endtask

  initial begin
    clear_cores();
    drive_cores();
    repeat (2) tick();
    check_val("reset_job_valid", job_valid_out, 0);
    check_val("reset_ack", core_res_ack_out, 0);
    check_val("reset_pix_valid", pix_valid_out, 0);
    check_val("reset_busy", busy_out, 0);
    check_val("reset_new_frame", new_frame_out, 0);
    check_val("reset_done", frame_done_out, 0);
    check_val("reset_scene", scene_out, 0);
    rst_in = 1'b1;
    tick();

    // round-robin collection with continuous ready
    ready_rand = 1'b0;
    pix_ready_in = 1'b1;
    drive_cores();
    rr_round("rr1", 4'b1111, 0, 1, 2, 3);
    rr_round("rr2", 4'b1111, 0, 1, 2, 3);
    rr_round("rr3", 4'b0101, 0, 2, 0, 0);
    rr_round("rr4", 4'b1010, 3, 1, 0, 0);

    // backpressure with two pending results
    pix_ready_in = 1'b0;
    drive_cores();
    ack_log.delete();
    out_q.delete();
    hold_mask(4'b0110);
    repeat (12) tick();
    check_val("bp_one_ack", ack_log.size(), 1);
    check_val("bp_valid_held", pix_valid_out, 1);
    check_val("bp_nothing_out", out_q.size(), 0);
    pix_ready_in = 1'b1;
    drive_cores();
    repeat (6) tick();
    check_val("bp_acks", ack_log.size(), 2);
    check_val("bp_outs", out_q.size(), 2);
    if (ack_log.size() == 2 && out_q.size() == 2) begin
      check_val("bp_first", ack_log[0], 2);
      check_val("bp_second", ack_log[1], 1);
      for (int j = 0; j < 2; j++)
        check_val("bp_data", {out_q[j].h, out_q[j].v, out_q[j].c},
                  {ack_log[j] * 5 + 2, ack_log[j] + 1, col_of(ack_log[j] * 5 + 2, ack_log[j] + 1)});
    end

    run_frame(8, 2, 0, 3, 3, 100, 1'b1);
    run_frame(8, 8, 2, 3, 3, 100, 1'b0);
    run_frame(6, 5, 2, 1, 4, 70, 1'b0);
    run_frame(0, 4, 1, 2, 2, 100, 1'b0);
    run_frame(7, 0, 0, 2, 2, 100, 1'b0);
    reset_mid_frame();
    run_frame(8, 2, 0, 3, 3, 100, 1'b0);
    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(12, 0), $urandom_range(6, 0), $urandom_range(3, 0),
                1, $urandom_range(6, 1), $urandom_range(100, 30), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ray_dispatch_engine.md
Name: ray_dispatch_engine

Overview:
- Parametrised, next-generation pixel scheduler and collector for a bank of NUM_CORES ray-marching cores.
- Latches per-frame scene inputs and walks the screen in raster order, optionally decimated by 2^decim so one sample covers a 2^decim x 2^decim block.
- Issues one pixel job per cycle to the lowest-indexed idle core.
- Collects results through a round-robin arbiter into an output stream with valid/ready backpressure, then reports frame completion.

Parameters:
- NUM_CORES, 8, number of ray cores, 1..32.
- H_BITS, 11, horizontal counter width.
- V_BITS, 10, vertical counter width.
- COLOR_BITS, 4, colour width per result.
- SCENE_BITS, 196, packed width of pos+dir vectors plus fractal select.
- MAX_DECIM, 3, largest legal decimation exponent.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-low reset.
- display_width_in  in  H_BITS  active pixels per row, sampled at frame start.
- display_height_in  in  V_BITS  active rows, sampled at frame start.
- decim_in  in  2  decimation exponent, sampled at frame start, clamped to MAX_DECIM.
- scene_in  in  SCENE_BITS  camera/fractal state, sampled at frame start.
- frame_req_in  in  1  request to start a new frame.
- scene_out  out  SCENE_BITS  latched scene, broadcast to all cores.
- job_h_out  out  H_BITS  job pixel column.
- job_v_out  out  V_BITS  job pixel row.
- job_valid_out  out  NUM_CORES  one-hot job strobe, 1 cycle.
- core_idle_in  in  NUM_CORES  core can accept a job.
- core_res_valid_in  in  NUM_CORES  core holds a result; stays high until acked.
- core_res_h_in  in  NUM_CORES*H_BITS  per-core result column.
- core_res_v_in  in  NUM_CORES*V_BITS  per-core result row.
- core_res_color_in  in  NUM_CORES*COLOR_BITS  per-core result colour.
- core_res_ack_out  out  NUM_CORES  one-hot result acknowledge, 1 cycle.
- pix_h_out  out  H_BITS  output pixel column.
- pix_v_out  out  V_BITS  output pixel row.
- pix_size_out  out  2  decim value for this pixel.
- pix_color_out  out  COLOR_BITS  output colour.
- pix_valid_out  out  1  output valid.
- pix_ready_in  in  1  downstream ready.
- busy_out  out  1  frame in progress.
- new_frame_out  out  1  1-cycle pulse when a frame starts.
- frame_done_out  out  1  1-cycle pulse when the last result of a frame is accepted downstream.

Behaviour:
- Reset (rst_in==0 at clk edge):
  - State IDLE.
  - All one-hot vectors, pix_valid_out, busy_out, new_frame_out and frame_done_out are 0.
  - Counters, scene_out and pix_* data are 0.
  - Reset mid-frame abandons the frame immediately; no done pulse is produced.
- State machine IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE, frame_req_in==1:
  - Latch scene, width, height and decim (clamped).
  - Set job h=v=0 and outstanding=0.
  - Pulse new_frame_out and go to ISSUE.
  - busy_out is 1 from the next cycle until DRAIN exits.
  - frame_req_in is ignored outside IDLE.
- ISSUE:
  - Each cycle, if any core_idle_in bit is set, strobe job_valid_out on the lowest such index with the current h/v.
  - Advance h by 2^decim.
  - If h+2^decim >= width: h=0, v+=2^decim.
  - If v+2^decim >= height on a row wrap, go to DRAIN.
  - A job issued at cycle t must not go to a core whose idle bit was used at t-1; cores deassert idle within 1 cycle.
- outstanding counter (width clog2(NUM_CORES+1)): +1 per issued job, -1 per ack; both in one cycle leaves it unchanged.
- DRAIN: when outstanding==0 and no result is held, pulse frame_done_out and go to IDLE.
- Collector:
  - Single output register.
  - When the register is empty, or pix_ready_in&&pix_valid_out, round-robin select the next core_res_valid_in index starting after the last-granted index.
  - Strobe core_res_ack_out for the selected core and load pix_* with its data next cycle.
  - Sustains 1 result/cycle under continuous ready.
  - pix_* is held stable while valid && !ready.
- Degenerate frames:
  - width==0 or height==0: go IDLE -> DRAIN directly; frame_done_out fires 2 cycles after the request.
  - Width not a multiple of 2^decim: the last partial block is still issued at its start coordinate.

Test Plan:
1. NUM_CORES=4, width=8, height=2, decim=0, all cores idle with 3-cycle latency, ready=1 -> 16 jobs; each (h,v) pair in 0..7 x 0..1 appears exactly once at the output; frame_done_out fires once, after the 16th output.
2. decim=2, width=8, height=8 -> exactly 4 jobs at (0,0),(4,0),(0,4),(4,4); pix_size_out=2.
3. All 4 cores assert res_valid simultaneously with ready=1 -> acks in order 0,1,2,3; the next contention round starts from core 0 after the last grant to 3.
4. pix_ready_in held 0 for 10 cycles with 2 results pending -> pix_* stable; no ack beyond the first held result; nothing lost after ready returns.
5. rst_in=0 during ISSUE at job 5 -> next cycle all outputs 0, busy_out=0; a new frame_req_in restarts at (0,0).
6. frame_req_in pulsed while busy -> ignored; scene_out unchanged until the next IDLE request.
